// File: rtl/axi_lite_mem_master_if.sv
// AXI4-Lite channel bundle shared by the memory master and its slaves.
interface axi_intf #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic aclk
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      input  aclk,
      output awaddr, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready,
      output araddr, arprot, arvalid,
      input  arready,
      input  rdata, rresp, rvalid,
      output rready
   );

   modport slave (
      input  aclk,
      input  awaddr, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready,
      input  araddr, arprot, arvalid,
      output arready,
      output rdata, rresp, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi_lite_mem_master.sv
// Single-outstanding core load/store to AXI4-Lite bridge.
// One transaction at a time, bounded response wait.
module axi_lite_mem_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   axi_intf.master                 axi
);
   localparam int SW = DATA_WIDTH / 8;
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CW-1:0] CLAST = CW'(LAST);

   typedef enum logic [2:0] {
      IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE
   } state_t;

   state_t                state;
   state_t                state_n;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [SW-1:0]         wstrb_q;
   logic                  aw_done;
   logic                  w_done;
   logic [CW-1:0]         cnt;
   logic                  expired;

   assign axi.awaddr = addr_q;
   assign axi.araddr = addr_q;
   assign axi.wdata  = wdata_q;
   assign axi.wstrb  = wstrb_q;
   assign axi.awprot = 3'b000;
   assign axi.arprot = 3'b000;

   assign expired = (TIMEOUT_CYCLES != 0) && (cnt == CLAST);

   always_comb begin
      state_n     = state;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      axi.awvalid = 1'b0;
      axi.wvalid  = 1'b0;
      axi.bready  = 1'b0;
      axi.arvalid = 1'b0;
      axi.rready  = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               state_n = req_we ? WR_REQ : RD_REQ;
         end
         WR_REQ: begin
            axi.awvalid = !aw_done;
            axi.wvalid  = !w_done;
            if ((aw_done || axi.awready) &&
                (w_done || axi.wready))
               state_n = WR_RESP;
         end
         WR_RESP: begin
            axi.bready = 1'b1;
            if (axi.bvalid || expired)
               state_n = DONE;
         end
         RD_REQ: begin
            axi.arvalid = 1'b1;
            if (axi.arready)
               state_n = RD_RESP;
         end
         RD_RESP: begin
            axi.rready = 1'b1;
            if (axi.rvalid || expired)
               state_n = DONE;
         end
         DONE: begin
            rsp_valid = 1'b1;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state     <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         cnt       <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_n;
         if (state == IDLE && req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (state == WR_REQ) begin
            if (axi.awvalid && axi.awready)
               aw_done <= 1'b1;
            if (axi.wvalid && axi.wready)
               w_done <= 1'b1;
         end
         // counter runs only while waiting on B or R
         if (state == WR_RESP || state == RD_RESP)
            cnt <= cnt + CW'(1);
         else
            cnt <= '0;
         if (state == WR_RESP) begin
            if (axi.bvalid)
               rsp_err <= (axi.bresp != 2'b00);
            else if (expired)
               rsp_err <= 1'b1;
         end
         if (state == RD_RESP) begin
            if (axi.rvalid) begin
               rsp_rdata <= axi.rdata;
               rsp_err   <= (axi.rresp != 2'b00);
            end else if (expired) begin
               rsp_rdata <= '0;
               rsp_err   <= 1'b1;
            end
         end
      end
   end
endmodule
